bcd2bin_seq: RTL and testbench
==============================

// Module: bcd2bin_seq
// PURPOSE
//  Sequential multi-digit BCD-to-binary converter; the inverse of the binary-to-BCD path.
//  Accepts a packed N-digit BCD word over a valid/ready handshake.
//  Converts it with the reverse double-dabble algorithm (shift right, then subtract 3
//  from every digit >= 8), one shift per cycle. Returns the binary result on a
//  valid/ready output. Sits between decimal front-panel/keypad capture and binary datapath.
// PARAMETERS
//  NDIGITS  4   number of BCD digits in in_bcd (1..8)
//  BIN_W    14  output width; must satisfy 2**BIN_W > 10**NDIGITS-1 (elab-time $error if not)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          in_bcd holds a word to convert
//  in_ready   out  1          block can accept a word
//  in_bcd     in   4*NDIGITS  packed BCD, digit 0 in [3:0]
//  out_valid  out  1          out_bin/out_err valid
//  out_ready  in   1          consumer takes result
//  out_bin    out  BIN_W      binary value of in_bcd
//  out_err    out  1          some input digit was > 9
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; in_ready=1, out_valid=0,
//    out_bin=0, out_err=0, shift counter=0, work register=0.
//  - FSM states and transitions:
//      IDLE: in_ready=1. On in_valid, capture in_bcd.
//            If all digits are <= 9: load work={in_bcd, BIN_W'0}, count=BIN_W, go to CONV.
//            Otherwise: out_err=1, out_bin=0, go straight to DONE.
//      CONV: in_ready=0. Each cycle: work = work >> 1; then every 4-bit digit field
//            of the upper 4*NDIGITS bits that is >= 8 gets -3; count--.
//            When count reaches 1 this cycle, go to DONE and load out_bin = low BIN_W bits
//            of the post-step value.
//      DONE: out_valid=1; out_bin and out_err stay stable until out_ready=1.
//            On out_ready: out_valid drops next cycle, go to IDLE.
//  - Latency, handshake to out_valid:
//      * valid words: BIN_W+1 cycles (15 for defaults).
//      * error words: 1 cycle.
//  - Throughput: one word per BIN_W+2 cycles. in_ready is never high while busy.
//    No result-to-input bypass in DONE.
//  - in_bcd is sampled only on the in_valid & in_ready cycle; later changes are ignored.
//  - out_ready while out_valid=0 has no effect.
//  - Flag an assertion error if out_valid drops without out_ready.
//  - out_err clears on the next accepted valid word.
//  - Reset mid-CONV or mid-DONE: abort immediately to reset values; the pending result is lost.
//  - Arithmetic is unsigned.
//  - Digit adjust never underflows: only applied when the digit is >= 8.
//  - After BIN_W shifts the BCD field of work is zero (assertion).
// STRUCTURE
//  - Package bcd_pkg:
//      * BCD_DIGIT_W=4, BCD_MAX=4'd9
//      * typedef enum logic [1:0] {IDLE, CONV, DONE} bcd_conv_state_t
//      * function bcd_bin_width(n) returning the minimum BIN_W for n digits
//  - Sub-module bcd_digit_adj: 4-bit combinational, d >= 8 ? d-3 : d.
//    Instantiated NDIGITS times via generate.
//  - Top holds the FSM, the work shift register and the $clog2(BIN_W+1)-bit counter.
// TESTING
//  1. in_bcd=16'h0000 -> out_bin=0, out_err=0, out_valid exactly 15 cycles after accept.
//  2. in_bcd=16'h1234 -> out_bin=14'd1234 (0x04D2); in_bcd=16'h9999 -> out_bin=14'd9999 (0x270F).
//  3. in_bcd=16'h12A4 -> out_err=1, out_bin=0, out_valid 1 cycle after accept.
//     The next word 16'h0042 -> out_bin=42, out_err=0.
//  4. Backpressure: out_ready held low 10 cycles after out_valid
//     -> out_bin/out_valid stable, in_ready=0 throughout.
//  5. Back-to-back with in_valid tied high, out_ready=1, inputs 0001/0010/0100/1000
//     -> results 1/10/100/1000 in order, one per 16 cycles.
//  6. rst_n pulsed low at CONV cycle 7 of 16'h5678 -> all outputs at reset values at once.
//     A fresh 16'h0007 then yields 7.
//  Plus: exhaustive 0000-9999 sweep vs reference model.
//  Plus: NDIGITS=2, BIN_W=7 build with 99 -> 99.

Source files
------------

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for the sequential BCD-to-binary converter:
//   digit width and maximum legal digit value, the converter FSM state type,
//   and helpers for digit validity and minimum binary width.
//   No ports (package).
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_conv_state_t;

    // Smallest w with 2**w > 10**n - 1, i.e. 2**w >= 10**n.
    function automatic int bcd_bin_width(input int n);
        longint unsigned lim;
        int              w;
        lim = 64'd1;
        w   = 0;
        for (int i = 0; i < n; i++) begin
            lim = lim * 64'd10;
        end
        while ((64'd1 << w) < lim) begin
            w++;
        end
        return w;
    endfunction

    // True when a 4-bit field is a legal decimal digit.
    function automatic logic bcd_digit_ok(input logic [BCD_DIGIT_W-1:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// -----------------------------------------------------------------------------
// bcd2bin_seq_if
//   Input and output handshake bundle of the BCD-to-binary converter.
//   Parameters NDIGITS / BIN_W must match the converter instance.
//
//   Signals:
//     in_valid  producer -> converter  in_bcd holds a word to convert
//     in_ready  converter -> producer  converter can accept a word
//     in_bcd    producer -> converter  packed BCD, digit 0 in [3:0]
//     out_valid converter -> consumer  out_bin/out_err valid
//     out_ready consumer -> converter  consumer takes the result
//     out_bin   converter -> consumer  binary value of the accepted word
//     out_err   converter -> consumer  some accepted digit was > 9
//
//   Handshake rule (both channels): a transfer happens on a rising clock edge
//   where valid and ready are both high. Once valid is raised it stays high,
//   with its payload unchanged, until that transfer; ready may change freely.
//
//   Modports: master = producer/consumer side, slave = converter side.
// -----------------------------------------------------------------------------
interface bcd2bin_seq_if #(
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14
);

    logic                   in_valid;
    logic                   in_ready;
    logic [4*NDIGITS-1:0]   in_bcd;
    logic                   out_valid;
    logic                   out_ready;
    logic [BIN_W-1:0]       out_bin;
    logic                   out_err;

    modport master (
        output in_valid,
        output in_bcd,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bin,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_bcd,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bin,
        output out_err
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
//   One digit of the reverse double-dabble correction: after the right shift a
//   digit that reads >= 8 received a carry-in of 8 from the digit above, which
//   in decimal is worth 5, so 3 is taken away. Purely combinational.
//
//   Ports:
//     d_i  in   4  digit field after the shift
//     d_o  out  4  corrected digit field
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_i,
    output logic [BCD_DIGIT_W-1:0] d_o
);

    // The subtraction only happens for d_i >= 8, so it never wraps.
    assign d_o = (d_i >= 4'd8) ? (d_i - 4'd3) : d_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// -----------------------------------------------------------------------------
// bcd2bin_seq
//   Sequential N-digit BCD-to-binary converter (reverse double-dabble).
//   An accepted word is loaded into the top of a work register; each CONV
//   cycle shifts the register right by one and corrects every BCD digit that
//   reads >= 8. After BIN_W steps the binary value sits in the low BIN_W bits.
//   Words with an illegal digit skip conversion and report out_err with
//   out_bin = 0.
//
//   Ports:
//     clk          in   1       rising-edge clock
//     rst_n        in   1       asynchronous active-low reset
//     bus          slave modport of bcd2bin_seq_if (in/out handshakes)
//     dbg_state_o  out  2       current FSM state, for observation only
//
//   Timing: valid words give out_valid BIN_W+1 cycles after the accepting
//   cycle, error words 1 cycle after; one word per BIN_W+2 cycles at best.
// -----------------------------------------------------------------------------
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd2bin_seq_if.slave     bus,
    output bcd_conv_state_t  dbg_state_o
);

    localparam int BCD_W  = BCD_DIGIT_W * NDIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (NDIGITS < 1 || NDIGITS > 8) begin : g_bad_ndigits
        $error("bcd2bin_seq: NDIGITS must be in 1..8");
    end

    if (BIN_W < bcd_bin_width(NDIGITS)) begin : g_bad_bin_w
        $error("bcd2bin_seq: BIN_W too small to hold 10**NDIGITS-1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    bcd_conv_state_t     state_q, state_d;
    logic [WORK_W-1:0]   work_q,  work_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [BIN_W-1:0]    out_bin_q, out_bin_d;
    logic                out_err_q, out_err_d;

    // ------------------------------------------------------------------
    // One conversion step: shift right, then correct the BCD digits.
    // ------------------------------------------------------------------
    logic [WORK_W-1:0]   shifted;
    logic [BCD_W-1:0]    adj_field;
    logic [WORK_W-1:0]   stepped;

    assign shifted = work_q >> 1;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .d_o (adj_field[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign stepped = {adj_field, shifted[BIN_W-1:0]};

    // ------------------------------------------------------------------
    // Input digit legality
    // ------------------------------------------------------------------
    logic in_digit_bad;

    always_comb begin
        in_digit_bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (!bcd_digit_ok(bus.in_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                in_digit_bad = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        out_bin_d = out_bin_q;
        out_err_d = out_err_q;

        case (state_q)
            IDLE: begin
                // in_ready is high in IDLE, so in_valid alone means accept.
                if (bus.in_valid) begin
                    if (in_digit_bad) begin
                        out_err_d = 1'b1;
                        out_bin_d = '0;
                        state_d   = DONE;
                    end else begin
                        out_err_d = 1'b0;
                        work_d    = {bus.in_bcd, {BIN_W{1'b0}}};
                        cnt_d     = CNT_W'(BIN_W);
                        state_d   = CONV;
                    end
                end
            end

            CONV: begin
                work_d = stepped;
                cnt_d  = cnt_q - CNT_W'(1);
                // cnt_q == 1 marks the last of the BIN_W steps.
                if (cnt_q == CNT_W'(1)) begin
                    out_bin_d = stepped[BIN_W-1:0];
                    state_d   = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            out_bin_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            out_bin_q <= out_bin_d;
            out_err_q <= out_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_bin   = out_bin_q;
    assign bus.out_err   = out_err_q;
    assign dbg_state_o   = state_q;

    // ------------------------------------------------------------------
    // Protocol and algorithm invariants
    // ------------------------------------------------------------------
    a_out_valid_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> bus.out_valid
    ) else $error("bcd2bin_seq: out_valid dropped without out_ready");

    // Every value below 2**BIN_W has shifted completely out of the BCD field.
    a_bcd_field_empty: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == CONV && cnt_q == CNT_W'(1)) |-> (stepped[WORK_W-1:BIN_W] == '0)
    ) else $error("bcd2bin_seq: BCD field not empty after final shift");

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;
    import bcd_pkg::*;

    localparam int ND   = 4;
    localparam int BW   = 14;
    localparam int TOUT = 60;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // ------------------------------------------------------------------
    // DUTs: default build and a 2-digit build
    // ------------------------------------------------------------------
    bcd2bin_seq_if #(.NDIGITS(ND), .BIN_W(BW)) bus ();
    bcd_conv_state_t dbg;

    bcd2bin_seq #(.NDIGITS(ND), .BIN_W(BW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg)
    );

    bcd2bin_seq_if #(.NDIGITS(2), .BIN_W(7)) bus2 ();
    bcd_conv_state_t dbg2;

    bcd2bin_seq #(.NDIGITS(2), .BIN_W(7)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus2),
        .dbg_state_o (dbg2)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: decimal value of the digits, error if any digit > 9
    // ------------------------------------------------------------------
    function automatic logic [BW:0] model(input logic [4*ND-1:0] w);
        int v;
        bit e;
        logic [3:0] d;
        v = 0;
        e = 1'b0;
        for (int i = ND - 1; i >= 0; i--) begin
            d = w[i*4 +: 4];
            if (d > 4'd9) e = 1'b1;
            v = v * 10 + int'(d);
        end
        if (e) return {1'b1, {BW{1'b0}}};
        return {1'b0, BW'(v)};
    endfunction

    function automatic logic [4*ND-1:0] rand_bcd();
        logic [4*ND-1:0] w;
        for (int i = 0; i < ND; i++) begin
            w[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard / compare process (samples on the falling edge)
    // ------------------------------------------------------------------
    logic [BW:0]     exp_q[$];
    int              acc_q[$];
    bit              busy = 1'b0;
    bit              seen = 1'b0;
    bit              hold = 1'b0;
    logic [BW-1:0]   hold_bin;
    logic            hold_err;
    bit              stop_rand = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                acc_q.delete();
                busy = 1'b0;
                seen = 1'b0;
                hold = 1'b0;
            end else begin
                check_eq("in_ready", bus.in_ready, !busy);
                if (!busy) check_eq("idle_out_valid", bus.out_valid, 0);
                if (hold) begin
                    check_eq("hold_valid", bus.out_valid, 1);
                    check_eq("hold_bin", bus.out_bin, hold_bin);
                    check_eq("hold_err", bus.out_err, hold_err);
                end
                if (busy && bus.out_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        check_eq("latency", cyc - acc_q[0], exp_q[0][BW] ? 1 : BW + 1);
                    end
                    check_eq("out_bin", bus.out_bin, exp_q[0][BW-1:0]);
                    check_eq("out_err", bus.out_err, exp_q[0][BW]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        busy = 1'b0;
                        seen = 1'b0;
                    end
                end else if (busy && (cyc - acc_q[0] > TOUT)) begin
                    check_eq("watchdog", cyc - acc_q[0], BW + 1);
                    exp_q.delete();
                    acc_q.delete();
                    busy = 1'b0;
                    seen = 1'b0;
                end
                hold     = bus.out_valid && !bus.out_ready;
                hold_bin = bus.out_bin;
                hold_err = bus.out_err;
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(model(bus.in_bcd));
                    acc_q.push_back(cyc);
                    busy = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (called at posedge+1)
    // ------------------------------------------------------------------
    task automatic send(input logic [4*ND-1:0] w);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_bcd   = w;
        @(negedge clk);
        while (!bus.in_ready && t < TOUT) begin
            @(negedge clk);
            t++;
        end
        check_eq("send_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_bcd   = 16'($urandom);
    endtask

    task automatic wait_out(input string name, input int exp_bin, input bit exp_err,
                            output int at);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < TOUT) begin
            @(negedge clk);
            t++;
        end
        check_eq({name, "_valid"}, bus.out_valid, 1);
        check_eq({name, "_bin"}, bus.out_bin, exp_bin);
        check_eq({name, "_err"}, bus.out_err, exp_err);
        at = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        check_eq({name, "_in_ready"}, bus.in_ready, 1);
        check_eq({name, "_out_valid"}, bus.out_valid, 0);
        check_eq({name, "_out_bin"}, bus.out_bin, 0);
        check_eq({name, "_out_err"}, bus.out_err, 0);
        check_eq({name, "_state"}, dbg, IDLE);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    localparam logic [15:0] B2B_W[4]   = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
    localparam int          B2B_EXP[4] = '{1, 10, 100, 1000};

    initial begin
        int at;
        int prev_at;
        int t;
        int n;

        bus.in_valid   = 1'b0;
        bus.in_bcd     = '0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_bcd    = '0;
        bus2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero word
        send(16'h0000);
        wait_out("zero", 0, 1'b0, at);

        // Typical and maximum values
        send(16'h1234);
        wait_out("v1234", 1234, 1'b0, at);
        send(16'h9999);
        wait_out("v9999", 9999, 1'b0, at);

        // Illegal digit, then recovery of out_err
        send(16'h12A4);
        wait_out("err12A4", 0, 1'b1, at);
        send(16'h0042);
        wait_out("v0042", 42, 1'b0, at);

        // Backpressure: result held for 10 cycles
        bus.out_ready = 1'b0;
        send(16'h0321);
        wait_out("bp", 321, 1'b0, at);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_valid", bus.out_valid, 1);
            check_eq("bp_bin", bus.out_bin, 321);
            check_eq("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_drop", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high
        bus.in_valid = 1'b1;
        bus.in_bcd   = B2B_W[0];
        prev_at      = 0;
        for (int i = 0; i < 4; i++) begin
            wait_out("b2b", B2B_EXP[i], 1'b0, at);
            if (i > 0) check_eq("b2b_gap", at - prev_at, BW + 2);
            prev_at = at;
            if (i < 3) bus.in_bcd = B2B_W[i+1];
            else       bus.in_valid = 1'b0;
        end

        // Reset in the middle of a conversion
        send(16'h5678);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0007);
        wait_out("v0007", 7, 1'b0, at);

        // Randomised words, gaps and consumer backpressure
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    n = $urandom_range(0, 3);
                    repeat (n) begin
                        @(posedge clk);
                        #1;
                    end
                    if (k % 8 == 7) send(16'($urandom));
                    else            send(rand_bcd());
                end
                t = 0;
                while (busy && t < 300) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("drain", busy, 0);
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join

        // Two-digit build
        bus2.in_valid = 1'b1;
        bus2.in_bcd   = 8'h99;
        t = 0;
        @(negedge clk);
        while (!bus2.in_ready && t < TOUT) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!bus2.out_valid && t < TOUT) begin
            @(negedge clk);
            t++;
        end
        check_eq("nd2_valid", bus2.out_valid, 1);
        check_eq("nd2_bin", bus2.out_bin, 99);
        check_eq("nd2_err", bus2.out_err, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #600000;
        $display("FAIL global_timeout: reached time limit at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "time limit");
    end

endmodule
